// File: rtl/iambic_keyer_core.sv
// Iambic Morse keyer core: straight, iambic-A, iambic-B and ultimatic paddle modes with dit/dah/gap timing.
// Define KEYER_SIDETONE_EN to build the sidetone divider on buzzer_o; otherwise buzzer_o is tied low.
module iambic_keyer_core #(
    parameter int TICK_DIV  = 1000,
    parameter int WPM_W     = 4,
    parameter int DAH_UNITS = 3,
    parameter int TONE_DIV  = 2000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WPM_W-1:0] wpm_sel_i,
    input  logic [1:0]       mode_i,
    input  logic             dit_i,
    input  logic             dah_i,
    output logic             key_o,
    output logic             aux_dit_o,
    output logic             aux_dah_o,
    output logic             buzzer_o,
    output logic             busy_o,
    output logic             elem_done_o
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = WPM_W + 1;
    localparam int UW = $clog2(DAH_UNITS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SPEED_MAX = {1'b1, {WPM_W{1'b0}}};
    localparam logic [UW-1:0] DAH_LAST  = UW'(DAH_UNITS - 1);

    localparam logic [1:0] MODE_STRAIGHT  = 2'b00;
    localparam logic [1:0] MODE_IAMBIC_A  = 2'b01;
    localparam logic [1:0] MODE_ULTIMATIC = 2'b11;

    if (TICK_DIV < 1 || DAH_UNITS < 2 || DAH_UNITS > 7 || TONE_DIV < 1) begin : g_bad_param
        $error("iambic_keyer_core: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, DIT, DAH, GAP} state_t;

    state_t        state;
    logic [1:0]    mode_q;
    logic          last_dah;     // element currently running, or the one the gap follows
    logic          mem_q;
    logic          recent_dah;
    logic          dit_prev;
    logic          dah_prev;
    logic [SW-1:0] speed_q;      // ticks per unit, frozen for the element and its gap
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] sub_cnt;
    logic [UW-1:0] unit_cnt;

    logic tick_last, unit_last, elem_last;
    logic opp_held, same_held, recent_now;
    logic go_opp, go_same;
    logic start_elem, start_dah;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tick_last = (tick_cnt == TICK_LAST);
        unit_last = tick_last && (sub_cnt == speed_q - SW'(1));
        elem_last = unit_last && (unit_cnt == ((state == DAH) ? DAH_LAST : '0));

        opp_held   = last_dah ? dit_i : dah_i;
        same_held  = last_dah ? dah_i : dit_i;
        recent_now = (dit_i && !dit_prev) ? 1'b0 :
                     (dah_i && !dah_prev) ? 1'b1 : recent_dah;

        go_opp  = 1'b0;
        go_same = 1'b0;
        if (mode_q == MODE_IAMBIC_A) begin
            go_opp  = opp_held;
            go_same = !opp_held && same_held;
        end else if (mode_q == MODE_ULTIMATIC && dit_i && dah_i) begin
            go_opp  = (recent_now != last_dah);
            go_same = !go_opp;
        end else begin
            go_opp  = opp_held || mem_q;
            go_same = !go_opp && same_held;
        end

        start_elem = 1'b0;
        start_dah  = 1'b0;
        if (state == IDLE && mode_i != MODE_STRAIGHT && (dit_i || dah_i)) begin
            start_elem = 1'b1;
            start_dah  = !dit_i;
        end else if (state == GAP && elem_last && (go_opp || go_same)) begin
            start_elem = 1'b1;
            start_dah  = go_opp ? !last_dah : last_dah;
        end
    end

    assign elem_done_o = (state == GAP) && elem_last;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            mode_q     <= MODE_STRAIGHT;
            last_dah   <= 1'b0;
            mem_q      <= 1'b0;
            recent_dah <= 1'b0;
            dit_prev   <= 1'b0;
            dah_prev   <= 1'b0;
            speed_q    <= '0;
            tick_cnt   <= '0;
            sub_cnt    <= '0;
            unit_cnt   <= '0;
            key_o      <= 1'b0;
            aux_dit_o  <= 1'b0;
            aux_dah_o  <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            dit_prev   <= dit_i;
            dah_prev   <= dah_i;
            recent_dah <= recent_now;
            if (state == IDLE)
                mode_q <= mode_i;

            if (start_elem) begin
                state     <= start_dah ? DAH : DIT;
                last_dah  <= start_dah;
                mem_q     <= 1'b0;
                speed_q   <= SPEED_MAX - {1'b0, wpm_sel_i};
                tick_cnt  <= '0;
                sub_cnt   <= '0;
                unit_cnt  <= '0;
                key_o     <= 1'b1;
                aux_dit_o <= !start_dah;
                aux_dah_o <= start_dah;
                busy_o    <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        mem_q     <= 1'b0;
                        key_o     <= (mode_i == MODE_STRAIGHT) && dit_i;
                        busy_o    <= (mode_i == MODE_STRAIGHT) && dit_i;
                        aux_dit_o <= 1'b0;
                        aux_dah_o <= 1'b0;
                    end
                    DIT, DAH, GAP: begin
                        if (opp_held)
                            mem_q <= 1'b1;
                        tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
                        if (tick_last)
                            sub_cnt <= unit_last ? '0 : sub_cnt + 1'b1;
                        if (unit_last)
                            unit_cnt <= unit_cnt + 1'b1;
                        if (elem_last) begin
                            unit_cnt  <= '0;
                            key_o     <= 1'b0;
                            aux_dit_o <= 1'b0;
                            aux_dah_o <= 1'b0;
                            if (state == GAP) begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                            end else begin
                                state <= GAP;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef KEYER_SIDETONE_EN
    localparam int NW = $clog2(TONE_DIV + 1);

    logic [NW-1:0] tone_cnt;
    logic          tone_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || !key_o) begin
            tone_cnt <= '0;
            tone_q   <= 1'b0;
        end else if (tone_cnt == NW'(TONE_DIV - 1)) begin
            tone_cnt <= '0;
            tone_q   <= !tone_q;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end

    // Gating with key_o keeps the tone from lingering a cycle after key release.
    assign buzzer_o = tone_q && key_o;
`else
    assign buzzer_o = 1'b0;
`endif

endmodule

// File: tb/tb_iambic_keyer_core.sv
// Scoreboard bench for iambic_keyer_core: a timeline-level model predicts keyed elements and gap-end pulses.
`timescale 1ns/1ps
module tb_iambic_keyer_core;

    localparam int TICK_DIV  = 4;
    localparam int WPM_W     = 4;
    localparam int DAH_UNITS = 3;
    localparam int TONE_DIV  = 2;
    localparam int N         = 320;
    localparam int ACT_END   = 140;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] wpm = 4'd14;
    logic [1:0] mode = 2'b00;
    logic       dit = 1'b0;
    logic       dah = 1'b0;
    logic       key, aux_dit, aux_dah, buzzer, busy, elem_done;

    iambic_keyer_core #(
        .TICK_DIV (TICK_DIV),
        .WPM_W    (WPM_W),
        .DAH_UNITS(DAH_UNITS),
        .TONE_DIV (TONE_DIV)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wpm_sel_i  (wpm),
        .mode_i     (mode),
        .dit_i      (dit),
        .dah_i      (dah),
        .key_o      (key),
        .aux_dit_o  (aux_dit),
        .aux_dah_o  (aux_dah),
        .buzzer_o   (buzzer),
        .busy_o     (busy),
        .elem_done_o(elem_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // typ: 0 dit, 1 dah, 2 straight (no aux), 3 inconsistent aux/busy
    typedef struct {
        int typ;
        int start;
        int len;
    } elem_t;

    elem_t exp_q[$];
    int    done_q[$];
    int    n_cmp = 0;
    int    n_fail = 0;

    bit tl_dit[N];
    bit tl_dah[N];
    int tl_w[N];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: measures each keyed pulse and each gap-end pulse, compares against the queues.
    logic  key_prev = 1'b0;
    int    cur_start, cur_len, cur_typ, t_now;
    elem_t e;
    always @(negedge clk) begin
        if (key) begin
            t_now = !busy                ? 3 :
                    (aux_dah && !aux_dit) ? 1 :
                    (aux_dit && !aux_dah) ? 0 :
                    (!aux_dit && !aux_dah) ? 2 : 3;
            if (!key_prev) begin
                cur_start = cyc;
                cur_len   = 0;
                cur_typ   = t_now;
            end else if (t_now != cur_typ) begin
                cur_typ = 3;
            end
            cur_len++;
        end else if (key_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_elem", cur_start, -1);
            end else begin
                e = exp_q.pop_front();
                check("elem_type", cur_typ, e.typ);
                check("elem_start", cur_start, e.start);
                check("elem_len", cur_len, e.len);
            end
        end
        if (elem_done) begin
            if (done_q.size() == 0) check("unexpected_done", cyc, -1);
            else check("done_cycle", cyc, done_q.pop_front());
        end
        if (!key && (aux_dit || aux_dah)) check("aux_without_key", 1, 0);
`ifndef KEYER_SIDETONE_EN
        if (buzzer) check("buzzer_off", 1, 0);
`endif
        key_prev = key;
    end

    function automatic bit pd(input int c, input bit dah_sel);
        if (c < 0 || c >= N) return 1'b0;
        return dah_sel ? tl_dah[c] : tl_dit[c];
    endfunction

    function automatic int w_at(input int c);
        return tl_w[(c < N) ? c : N - 1];
    endfunction

    // Timeline model: walks element by element using unit arithmetic and the paddle-choice rules.
    task automatic model(input int mode_v, input int base);
        int    t, s, u, l, g, len;
        bit    is_dah, opp_any, recent, nxt_valid, nxt_dah;
        elem_t x;
        if (mode_v == 0) begin
            for (int c = 0; c < N; c++) begin
                if (pd(c, 1'b0) && !pd(c - 1, 1'b0)) begin
                    len = 0;
                    while (pd(c + len, 1'b0)) len++;
                    x.typ = 2; x.start = base + c + 1; x.len = len;
                    exp_q.push_back(x);
                end
            end
            return;
        end
        t = 0;
        while (1) begin
            while (t < N && !pd(t, 1'b0) && !pd(t, 1'b1)) t++;
            if (t >= N) break;
            is_dah = !pd(t, 1'b0);
            s = t + 1;
            do begin
                u = TICK_DIV * (16 - w_at(s - 1));
                l = is_dah ? DAH_UNITS * u : u;
                g = s + l + u - 1;
                x.typ = int'(is_dah); x.start = base + s; x.len = l;
                exp_q.push_back(x);
                done_q.push_back(base + g);
                opp_any = 1'b0;
                for (int c = s; c <= g; c++) if (pd(c, !is_dah)) opp_any = 1'b1;
                nxt_valid = 1'b1;
                nxt_dah   = is_dah;
                if (mode_v == 3 && pd(g, 1'b0) && pd(g, 1'b1)) begin
                    recent = 1'b0;
                    for (int c = 0; c <= g; c++) begin
                        if (pd(c, 1'b0) && !pd(c - 1, 1'b0)) recent = 1'b0;
                        else if (pd(c, 1'b1) && !pd(c - 1, 1'b1)) recent = 1'b1;
                    end
                    nxt_dah = recent;
                end else if (mode_v == 1 ? pd(g, !is_dah) : opp_any) begin
                    nxt_dah = !is_dah;
                end else if (!pd(g, is_dah)) begin
                    nxt_valid = 1'b0;
                end
                s = g + 1;
                is_dah = nxt_dah;
            end while (nxt_valid);
            t = g + 1;
        end
    endtask

    task automatic clear_tl(input int w);
        for (int i = 0; i < N; i++) begin
            tl_dit[i] = 1'b0;
            tl_dah[i] = 1'b0;
            tl_w[i]   = w;
        end
    endtask

    task automatic set_range(input bit dah_sel, input int a, input int len);
        for (int i = a; i < a + len && i < ACT_END; i++) begin
            if (dah_sel) tl_dah[i] = 1'b1;
            else tl_dit[i] = 1'b1;
        end
    endtask

    task automatic run(input int mode_v);
        int base;
        @(posedge clk); #1;
        base = cyc;
        model(mode_v, base);
        mode = 2'(mode_v);
        for (int i = 0; i < N; i++) begin
            dit = tl_dit[i];
            dah = tl_dah[i];
            wpm = 4'(tl_w[i]);
            @(posedge clk); #1;
        end
        check("elems_left", exp_q.size(), 0);
        check("dones_left", done_q.size(), 0);
        check("busy_idle", int'(busy), 0);
        exp_q.delete();
        done_q.delete();
    endtask

    task automatic reset_mid_dah();
        int    base;
        elem_t x;
        @(posedge clk); #1;
        base = cyc;
        mode = 2'b01;
        wpm  = 4'd14;
        x.typ = 1; x.start = base + 1; x.len = 10;
        exp_q.push_back(x);
        dah = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (i == 3) dah = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_key", int'(key), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_aux", int'(aux_dit | aux_dah), 0);
        check("rst_done", int'(elem_done), 0);
        repeat (40) @(posedge clk);
        #1;
        check("rst_elems_left", exp_q.size(), 0);
        check("rst_dones_left", done_q.size(), 0);
        exp_q.delete();
        done_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_key", int'(key), 0);
        check("reset_aux_dit", int'(aux_dit), 0);
        check("reset_aux_dah", int'(aux_dah), 0);
        check("reset_buzzer", int'(buzzer), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(elem_done), 0);
        rst = 1'b0;

        clear_tl(14); set_range(1'b0, 0, 1); run(1);
        clear_tl(14); set_range(1'b1, 0, 60); run(1);
        clear_tl(14); set_range(1'b0, 0, 3); set_range(1'b1, 0, 3); run(2);
        clear_tl(14); set_range(1'b0, 0, 3); set_range(1'b1, 0, 3); run(1);
        clear_tl(14); set_range(1'b0, 0, 5); set_range(1'b1, 2, 10); run(0);
        clear_tl(14); set_range(1'b1, 0, 40);
        for (int i = 10; i < N; i++) tl_w[i] = 15;
        run(1);
        clear_tl(14); set_range(1'b1, 0, 100); set_range(1'b0, 20, 50); run(3);
        reset_mid_dah();

        repeat (24) begin
            int m, w0, w1, p;
            m  = int'($urandom_range(0, 3));
            w0 = int'($urandom_range(12, 15));
            w1 = int'($urandom_range(12, 15));
            p  = int'($urandom_range(0, N - 1));
            clear_tl(w0);
            for (int i = p; i < N; i++) tl_w[i] = w1;
            repeat ($urandom_range(1, 3))
                set_range(1'b0, int'($urandom_range(0, 110)), int'($urandom_range(1, 40)));
            repeat ($urandom_range(1, 3))
                set_range(1'b1, int'($urandom_range(0, 110)), int'($urandom_range(1, 40)));
            run(m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/iambic_keyer_core.md
IAMBIC_KEYER_CORE -- requirements
Module: iambic_keyer_core

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000: clock cycles per timing tick, >=1.
REQ-002 SHALL have parameter WPM_W, default 4: width of wpm_sel_i.
REQ-003 SHALL have parameter DAH_UNITS, default 3: dah length in units, range 2..7.
REQ-004 SHALL have parameter TONE_DIV, default 2000: sidetone half-period in clock cycles.
REQ-005 SHALL have port clk_i, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port wpm_sel_i, input, WPM_W: speed code w.
REQ-008 SHALL have port mode_i, input, 2: 00 straight, 01 iambic-A, 10 iambic-B, 11 ultimatic.
REQ-009 SHALL have ports dit_i and dah_i, input, 1 each: paddles, active-high, already synchronous to clk_i.
REQ-010 SHALL have port key_o, output, 1: Morse keying, active-high.
REQ-011 SHALL have ports aux_dit_o and aux_dah_o, output, 1 each: high while a dit or dah element is keyed.
REQ-012 SHALL have port buzzer_o, output, 1: sidetone square wave.
REQ-013 SHALL have port busy_o, output, 1: high in any state other than IDLE.
REQ-014 SHALL have port elem_done_o, output, 1: one-cycle pulse on the last cycle of each inter-element gap.

Function
REQ-015 SHALL define unit length as TICK_DIV*(2**WPM_W - w) cycles; w=0 slowest, w=2**WPM_W-1 fastest.
REQ-016 SHALL sample wpm_sel_i on the cycle an element starts; changes mid-element SHALL NOT affect the current element or its gap.
REQ-017 SHALL sample mode_i only in IDLE; changes while busy_o=1 take effect after return to IDLE.
REQ-018 Straight mode: key_o SHALL equal dit_i delayed by one cycle; dah_i, aux_dit_o and aux_dah_o ignored/held 0; busy_o=key_o.
REQ-019 FSM SHALL use states IDLE, DIT, DAH, GAP; DIT lasts 1 unit, DAH DAH_UNITS units, GAP 1 unit with key_o=0.
REQ-020 IDLE->DIT when dit_i=1; IDLE->DAH when dah_i=1 and dit_i=0; both pressed in the same cycle: DIT wins; key_o rises the cycle after the press.
REQ-021 Memory latch SHALL set when the paddle opposite the current element is seen high during DIT/DAH/GAP, and clear on entry to the next element.
REQ-022 At GAP end, iambic-A: next = opposite if opposite paddle currently held, else same if same paddle held, else IDLE; memory latch ignored.
REQ-023 At GAP end, iambic-B: next = opposite if opposite held or memory latch set, else same if held, else IDLE.
REQ-024 Ultimatic: while both held, repeat the element of the paddle pressed most recently; single paddle repeats its own element; memory as iambic-B.
REQ-025 aux_dit_o/aux_dah_o SHALL equal key_o gated by DIT/DAH state respectively.
REQ-026 Unit and tick counters SHALL be wide enough for TICK_DIV*(2**WPM_W) and DAH_UNITS without overflow; no wrap-around within an element.

Reset
REQ-027 While rst_i=1: state IDLE, counters and memory latch 0; key_o, aux_dit_o, aux_dah_o, buzzer_o, busy_o, elem_done_o all 0 on the next edge.
REQ-028 Reset asserted mid-element SHALL abort it immediately with no GAP and no elem_done_o pulse.

Configuration
REQ-029 Macro KEYER_SIDETONE_EN defined: buzzer_o toggles every TONE_DIV cycles while key_o=1, held 0 and divider cleared while key_o=0.
REQ-030 Macro KEYER_SIDETONE_EN undefined: tone divider absent, buzzer_o tied 0.

Verification (TICK_DIV=4, WPM_W=4, DAH_UNITS=3, w=14 -> unit 8 cycles)
REQ-031 Iambic-A, dit_i pulsed 1 cycle -> key_o high 8 cycles, low 8, elem_done_o on gap cycle 8, busy_o low after.
REQ-032 Iambic-A, dah_i held 60 cycles -> dah 24 on, 8 off, dah 24 on, 8 off, IDLE.
REQ-033 Both paddles pressed together, released during first dit: iambic-B -> dit then dah; iambic-A -> dit only.
REQ-034 Straight mode, dit_i high 5 cycles -> key_o high 5 cycles, 1 cycle later; aux outputs stay 0.
REQ-035 rst_i pulsed during dah cycle 10 -> all outputs 0 next cycle, busy_o 0; wpm change to w=15 mid-dah -> current dah stays 24 cycles, next element 4-cycle unit.
REQ-036 With KEYER_SIDETONE_EN, TONE_DIV=2, dit -> buzzer_o toggles every 2 cycles during the 8 key_o cycles, 0 otherwise.
